// File: rtl/matrix_host_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_host_sequencer_pkg
// Brief    : Shared types and default sizes for the matrix host sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_host_sequencer_pkg;

  localparam int DATA_W  = 8;   // element width in bits
  localparam int ELEMS   = 4;   // elements per matrix (2x2)
  localparam int TIMEOUT = 64;  // cycles allowed in WAIT before giving up

  typedef enum logic [1:0] {
    SEQ_LOAD = 2'd0,
    SEQ_WAIT = 2'd1,
    SEQ_READ = 2'd2,
    SEQ_HOLD = 2'd3
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/matrix_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : matrix_host_sequencer
// Brief    : Host-side initiator for the matrix controller. Streams A then B
//            onto the load bus, waits for done, reads C back out onto a
//            valid/ready result stream. Sticky timeout if done never comes.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_host_sequencer
  import matrix_host_sequencer_pkg::*;
#(
  parameter int DATA_W  = matrix_host_sequencer_pkg::DATA_W,
  parameter int ELEMS   = matrix_host_sequencer_pkg::ELEMS,
  parameter int TIMEOUT = matrix_host_sequencer_pkg::TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  // operand stream in
  input  logic                      s_valid,
  input  logic [DATA_W-1:0]         s_data,
  output logic                      s_ready,
  // load bus to controller
  output logic                      load_en,
  output logic                      load_sel_ab,
  output logic [$clog2(ELEMS)-1:0]  load_index,
  output logic [DATA_W-1:0]         in_data,
  // completion and readout
  input  logic                      done,
  output logic                      output_en,
  output logic [$clog2(ELEMS)-1:0]  output_sel,
  input  logic [DATA_W-1:0]         out_data,
  // result stream out
  output logic                      m_valid,
  output logic [DATA_W-1:0]         m_data,
  input  logic                      m_ready,
  // status
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int IDX_W = $clog2(ELEMS);
  localparam int LD_W  = IDX_W + 1;          // counts A then B: MSB selects matrix
  localparam int WT_W  = $clog2(TIMEOUT);

  localparam logic [LD_W-1:0]  LD_LAST = LD_W'(2 * ELEMS - 1);
  localparam logic [IDX_W-1:0] RD_LAST = IDX_W'(ELEMS - 1);
  localparam logic [WT_W-1:0]  WT_LAST = WT_W'(TIMEOUT - 1);

  seq_state_t        state_q, state_d;
  logic [LD_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [WT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              timeout_err_q, timeout_err_d;

  logic              load_en_q;
  logic              load_sel_q;
  logic [IDX_W-1:0]  load_idx_q;
  logic [DATA_W-1:0] in_data_q;
  logic              m_valid_q;
  logic [DATA_W-1:0] m_data_q;

  logic              ld_hs;
  logic              m_hs;

  assign ld_hs = s_valid && (state_q == SEQ_LOAD);
  assign m_hs  = m_valid_q && m_ready;

  // State, counters and all registered outputs; rst discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEQ_LOAD;
      ld_cnt_q      <= '0;
      rd_idx_q      <= '0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      load_en_q     <= 1'b0;
      load_sel_q    <= 1'b0;
      load_idx_q    <= '0;
      in_data_q     <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
    end else begin
      state_q       <= state_d;
      ld_cnt_q      <= ld_cnt_d;
      rd_idx_q      <= rd_idx_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
      // One load strobe per accepted byte, in the cycle after the handshake.
      load_en_q     <= ld_hs;
      if (ld_hs) begin
        load_sel_q <= ld_cnt_q[LD_W-1];
        load_idx_q <= ld_cnt_q[IDX_W-1:0];
        in_data_q  <= s_data;
      end
      // Capture C in READ; hold it untouched until the consumer takes it.
      if (state_q == SEQ_READ) begin
        m_valid_q <= 1'b1;
        m_data_q  <= out_data;
      end else if (m_hs) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  // Next-state and counter update; done has priority over the timeout.
  always_comb begin
    state_d       = state_q;
    ld_cnt_d      = ld_cnt_q;
    rd_idx_d      = rd_idx_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      SEQ_LOAD: begin
        if (ld_hs) begin
          if (ld_cnt_q == LD_LAST) begin
            ld_cnt_d = '0;
            state_d  = SEQ_WAIT;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end
      SEQ_WAIT: begin
        if (done) begin
          wait_cnt_d = '0;
          state_d    = SEQ_READ;
        end else if (wait_cnt_q == WT_LAST) begin
          wait_cnt_d    = '0;
          timeout_err_d = 1'b1;
          state_d       = SEQ_LOAD;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      SEQ_READ: begin
        state_d = SEQ_HOLD;
      end
      SEQ_HOLD: begin
        if (m_hs) begin
          if (rd_idx_q == RD_LAST) begin
            rd_idx_d = '0;
            state_d  = SEQ_LOAD;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
            state_d  = SEQ_READ;
          end
        end
      end
      default: begin
        state_d = SEQ_LOAD;
      end
    endcase
  end

  // State-decoded outputs; busy drops only when idle at the start of a load.
  always_comb begin
    s_ready    = (state_q == SEQ_LOAD);
    output_en  = (state_q == SEQ_READ);
    output_sel = (state_q == SEQ_READ) ? rd_idx_q : '0;
    busy       = !((state_q == SEQ_LOAD) && (ld_cnt_q == '0));
  end

  assign load_en     = load_en_q;
  assign load_sel_ab = load_sel_q;
  assign load_index  = load_idx_q;
  assign in_data     = in_data_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_host_sequencer
// Brief    : Randomized self-checking bench for matrix_host_sequencer with a
//            behavioural 2x2 matrix controller stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_host_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       load_en;
  logic       load_sel_ab;
  logic [1:0] load_index;
  logic [7:0] in_data;
  logic       done;
  logic       output_en;
  logic [1:0] output_sel;
  logic [7:0] out_data;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       busy;
  logic       timeout_err;

  int n_vec;
  int n_err;
  int cyc;
  bit te_sticky;

  // controller stub state
  logic [7:0] a_m [4];
  logic [7:0] b_m [4];
  logic [7:0] c_m [4];
  int         ld_seen;
  int         w;
  int         done_at;
  bit         armed;
  bit         spur_done;

  always #5 clk = ~clk;

  matrix_host_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .load_en     (load_en),
    .load_sel_ab (load_sel_ab),
    .load_index  (load_index),
    .in_data     (in_data),
    .done        (done),
    .output_en   (output_en),
    .output_sel  (output_sel),
    .out_data    (out_data),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // Stub controller: latches loaded elements, pulses done done_at cycles into WAIT.
  always @(posedge clk) begin
    if (rst) begin
      ld_seen <= 0;
      armed   <= 1'b0;
      w       <= 0;
    end else if (load_en) begin
      if (load_sel_ab) b_m[load_index] <= in_data;
      else             a_m[load_index] <= in_data;
      if (ld_seen == 7) begin
        ld_seen <= 0;
        armed   <= 1'b1;
        w       <= 1;
      end else begin
        ld_seen <= ld_seen + 1;
      end
    end else if (armed) begin
      if (w == done_at || w >= 70) armed <= 1'b0;
      w <= w + 1;
    end
  end

  assign done = (armed && (w == done_at)) || spur_done;

  // Stub array result: C = A x B (2x2, row-major), modulo 256.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      c_m[k] = 8'((int'(a_m[2*(k/2)]) * int'(b_m[k%2])) +
                  (int'(a_m[2*(k/2)+1]) * int'(b_m[2+(k%2)])));
    end
  end

  assign out_data = output_en ? c_m[output_sel] : 8'h00;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One complete transaction. gap_pct<0 alternates s_valid; abort_mv stops at first result.
  task automatic run_txn(input int gap_pct, input int rdy_pct, input int dly,
                         input bit expect_to, input bit abort_mv, input bit fixed);
    logic [7:0] bytes [8];
    logic [7:0] exp_c [4];
    logic [7:0] prev_md;
    int  sent, got, loads, t_wait, start, acc;
    bit  hs_ld, hs_m, prev_mv, to_exp, vbit;

    for (int k = 0; k < 8; k++) bytes[k] = fixed ? 8'(k + 1) : 8'($urandom_range(255));
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        acc = 0;
        for (int kk = 0; kk < 2; kk++) acc += int'(bytes[r*2+kk]) * int'(bytes[4+kk*2+c]);
        exp_c[r*2+c] = 8'(acc);
      end
    end

    done_at = dly;
    sent = 0; got = 0; loads = 0; t_wait = 0; start = cyc; to_exp = 1'b0;
    forever begin
      if (gap_pct < 0) vbit = (((cyc - start) % 2) == 1);
      else             vbit = ($urandom_range(99) >= gap_pct);
      s_valid   = (sent < 8) && vbit;
      s_data    = (sent < 8) ? bytes[sent] : 8'h00;
      m_ready   = ($urandom_range(99) < rdy_pct);
      spur_done = (sent < 8) && ($urandom_range(99) < 20);

      @(negedge clk);
      hs_ld   = s_valid && s_ready;
      hs_m    = m_valid && m_ready;
      prev_mv = m_valid;
      prev_md = m_data;
      if (hs_m) begin
        check_val("m_data", 32'(m_data), 32'(exp_c[got]));
        got++;
      end
      if (hs_ld) sent++;

      @(posedge clk);
      #1;
      cyc++;
      if (hs_ld && sent == 8) t_wait = cyc;
      to_exp = expect_to && (sent == 8) && (cyc - t_wait >= 64);

      check_val("load_en", 32'(load_en), 32'(hs_ld));
      if (load_en) begin
        if (loads < 8)
          check_val("load_tuple", {21'd0, load_sel_ab, load_index, in_data},
                    {21'd0, loads >= 4, 2'(loads % 4), bytes[loads]});
        else
          check_val("load_extra", 32'(loads), 32'd7);
        loads++;
      end
      if (prev_mv && !hs_m) begin
        check_val("m_hold_valid", 32'(m_valid), 32'd1);
        check_val("m_hold_data", 32'(m_data), 32'(prev_md));
      end
      if (output_en) check_val("output_sel", 32'(output_sel), 32'(got));
      if (hs_ld && sent == 8) check_val("s_ready_wait", 32'(s_ready), 32'd0);
      check_val("timeout_err", 32'(timeout_err), 32'(te_sticky || to_exp));
      check_val("busy", 32'(busy), 32'((sent != 0) && (got < 4) && !to_exp));

      if (got == 4 || to_exp) begin
        check_val("s_ready_end", 32'(s_ready), 32'd1);
        break;
      end
      if (abort_mv && m_valid) break;
      if (cyc - start > 1500) begin
        check_val("txn_bound", 32'(cyc - start), 32'd0);
        break;
      end
    end
    if (to_exp) te_sticky = 1'b1;
    s_valid   = 1'b0;
    m_ready   = 1'b0;
    spur_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0; spur_done = 1'b0;
    done_at = 1000; cyc = 0; n_vec = 0; n_err = 0; te_sticky = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_s_ready", 32'(s_ready), 32'd1);
    check_val("rst_load_en", 32'(load_en), 32'd0);
    check_val("rst_output_en", 32'(output_en), 32'd0);
    check_val("rst_m_valid", 32'(m_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;

    // bytes 1..8 back-to-back, consumer always ready
    run_txn(0, 100, 3, 1'b0, 1'b0, 1'b1);
    // alternating s_valid, stalls on the result side
    run_txn(-1, 50, 10, 1'b0, 1'b0, 1'b0);
    // long consumer stalls
    run_txn(0, 8, 5, 1'b0, 1'b0, 1'b0);
    // random mixes
    for (int i = 0; i < 6; i++)
      run_txn(int'($urandom_range(60)), int'($urandom_range(90, 10)),
              int'($urandom_range(40, 1)), 1'b0, 1'b0, 1'b0);
    // done arrives on the last permitted WAIT cycle: must win over timeout
    run_txn(20, 70, 63, 1'b0, 1'b0, 1'b0);
    // done never arrives
    run_txn(0, 100, 1000, 1'b1, 1'b0, 1'b0);

    // reset while a result is pending
    run_txn(0, 0, 5, 1'b0, 1'b1, 1'b0);
    check_val("pre_rst_m_valid", 32'(m_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    te_sticky = 1'b0;
    check_val("midrst_m_valid", 32'(m_valid), 32'd0);
    check_val("midrst_s_ready", 32'(s_ready), 32'd1);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_load_en", 32'(load_en), 32'd0);
    check_val("midrst_output_en", 32'(output_en), 32'd0);
    check_val("midrst_timeout_err", 32'(timeout_err), 32'd0);
    run_txn(30, 60, 7, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
